netfpga_sume_10g_tx_arbiter: RTL

NETFPGA_SUME_10G_TX_ARBITER -- requirements
Module: netfpga_sume_10g_tx_arbiter

---
 rtl/netfpga_sume_10g_tx_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/netfpga_sume_10g_tx_arbiter.sv
// Two-port AXI-Stream arbiter feeding the 10GbE MAC TX stream; frames are never interleaved.
// Optional per-port frame counters are enabled by defining TX_ARB_PKT_CNT_EN.
module netfpga_sume_10g_tx_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk156,
  input  logic        areset_clk156,
  input  logic [63:0] s0_axis_tdata,
  input  logic [7:0]  s0_axis_tkeep,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  output logic        s0_axis_tready,
  input  logic [63:0] s1_axis_tdata,
  input  logic [7:0]  s1_axis_tkeep,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  output logic        s1_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [1:0]  grant
`ifdef TX_ARB_PKT_CNT_EN
  ,
  output logic [31:0] pkt_cnt0,
  output logic [31:0] pkt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  state_t arb_pick;
  logic   last_port;
  logic   last_eff;
  logic   done0;
  logic   done1;

  assign done0 = (state == GNT0) && s0_axis_tvalid && s0_axis_tlast && m_axis_tready;
  assign done1 = (state == GNT1) && s1_axis_tvalid && s1_axis_tlast && m_axis_tready;

  // A finishing port counts as last served already in the cycle it ends its frame.
  always_comb begin
    last_eff = last_port;
    if (done0) begin
      last_eff = 1'b0;
    end else if (done1) begin
      last_eff = 1'b1;
    end
  end

  always_comb begin
    arb_pick = IDLE;
    if ((RR_EN != 0) && s0_axis_tvalid && s1_axis_tvalid) begin
      arb_pick = last_eff ? GNT0 : GNT1;
    end else if (s0_axis_tvalid) begin
      arb_pick = GNT0;
    end else if (s1_axis_tvalid) begin
      arb_pick = GNT1;
    end
  end

  always_comb begin
    state_next     = state;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        state_next = arb_pick;
      end
      GNT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
        if (done0) begin
          state_next = arb_pick;
        end
      end
      GNT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
        if (done1) begin
          state_next = arb_pick;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign grant = {state == GNT1, state == GNT0};

  // last_port resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      state     <= IDLE;
      last_port <= 1'b1;
    end else begin
      state <= state_next;
      if (done0) begin
        last_port <= 1'b0;
      end else if (done1) begin
        last_port <= 1'b1;
      end
    end
  end

`ifdef TX_ARB_PKT_CNT_EN
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (done0) begin
        pkt_cnt0 <= pkt_cnt0 + 32'd1;
      end
      if (done1) begin
        pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end
    end
  end
`endif

endmodule
